sdrc_app_mem_responder: RTL and testbench

//  Synthesizable responder for the sdrc_core application request interface (app_req/ack, wr_next_req, rd_valid/last_rd).

---
 rtl/sdrc_app_mem_responder.sv | 182 ++++++++++++++++++
 tb/tb_sdrc_app_mem_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_app_mem_responder.sv
// Stand-in for sdrc_core + SDRAM on the application request interface.
// Serves one burst at a time out of an on-chip word RAM with per-byte write enables.
module sdrc_app_mem_responder #(
   parameter int DW      = 32,
   parameter int AW      = 10,
   parameter int ACK_DLY = 2,
   parameter int RD_LAT  = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            app_req,
   input  logic [29:0]     app_req_addr,
   input  logic [8:0]      app_req_len,
   input  logic            app_req_wr_n,
   output logic            app_req_ack,
   input  logic [DW-1:0]   app_wr_data,
   input  logic [DW/8-1:0] app_wr_en_n,
   output logic            app_wr_next_req,
   output logic            app_rd_valid,
   output logic            app_last_rd,
   output logic [DW-1:0]   app_rd_data,
   output logic            busy
);

   localparam int BE    = DW / 8;
   localparam int DEPTH = 1 << AW;
   localparam int CW    = 16;
   localparam logic [CW-1:0] ACK_LAST = CW'(ACK_DLY - 1);
   localparam logic [CW-1:0] RD_LAST  = CW'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACK_WAIT = 3'd1,
      ST_ACK      = 3'd2,
      ST_WR       = 3'd3,
      ST_RD_WAIT  = 3'd4,
      ST_RD       = 3'd5
   } state_t;

   state_t          state_r;
   logic [CW-1:0]   dly_cnt_r;
   logic [AW-1:0]   ptr_r;
   logic [8:0]      rem_r;
   logic            wr_n_r;
   logic            ack_r;
   logic            wr_next_r;
   logic            rd_valid_r;
   logic            last_r;
   logic [DW-1:0]   rd_data_r;
   logic [DW-1:0]   mem_r [DEPTH];

   logic            wr_fire_s;
   logic [DW-1:0]   rd_word_s;
   logic            unused_addr_s;

   // Address bits above the RAM index are deliberately ignored.
   assign unused_addr_s = ^app_req_addr[29:AW];

   assign wr_fire_s = (state_r == ST_WR) && wr_next_r && !reset;
   assign rd_word_s = mem_r[ptr_r];

   assign app_req_ack     = ack_r;
   assign app_wr_next_req = wr_next_r;
   assign app_rd_valid    = rd_valid_r;
   assign app_last_rd     = last_r;
   assign app_rd_data     = rd_data_r;
   assign busy            = (state_r != ST_IDLE);

   // Request handshake, burst sequencing and registered interface outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         dly_cnt_r  <= {CW{1'b0}};
         ptr_r      <= {AW{1'b0}};
         rem_r      <= 9'd0;
         wr_n_r     <= 1'b0;
         ack_r      <= 1'b0;
         wr_next_r  <= 1'b0;
         rd_valid_r <= 1'b0;
         last_r     <= 1'b0;
         rd_data_r  <= {DW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               dly_cnt_r <= {CW{1'b0}};
               if (app_req) begin
                  state_r <= ST_ACK_WAIT;
               end
            end
            ST_ACK_WAIT: begin
               if (!app_req) begin
                  state_r   <= ST_IDLE;
                  dly_cnt_r <= {CW{1'b0}};
               end else if (dly_cnt_r == ACK_LAST) begin
                  state_r   <= ST_ACK;
                  ack_r     <= 1'b1;
                  ptr_r     <= app_req_addr[AW-1:0];
                  rem_r     <= app_req_len;
                  wr_n_r    <= app_req_wr_n;
                  dly_cnt_r <= {CW{1'b0}};
               end else begin
                  dly_cnt_r <= dly_cnt_r + CW'(1);
               end
            end
            ST_ACK: begin
               ack_r <= 1'b0;
               if (rem_r == 9'd0) begin
                  state_r <= ST_IDLE;
               end else if (!wr_n_r) begin
                  state_r   <= ST_WR;
                  wr_next_r <= 1'b1;
               end else if (RD_LAT == 1) begin
                  state_r    <= ST_RD;
                  rd_valid_r <= 1'b1;
                  rd_data_r  <= rd_word_s;
                  last_r     <= (rem_r == 9'd1);
                  ptr_r      <= ptr_r + AW'(1);
                  rem_r      <= rem_r - 9'd1;
               end else begin
                  state_r <= ST_RD_WAIT;
               end
            end
            ST_WR: begin
               ptr_r <= ptr_r + AW'(1);
               rem_r <= rem_r - 9'd1;
               if (rem_r == 9'd1) begin
                  wr_next_r <= 1'b0;
                  state_r   <= ST_IDLE;
               end
            end
            ST_RD_WAIT: begin
               if (dly_cnt_r == RD_LAST) begin
                  state_r    <= ST_RD;
                  dly_cnt_r  <= {CW{1'b0}};
                  rd_valid_r <= 1'b1;
                  rd_data_r  <= rd_word_s;
                  last_r     <= (rem_r == 9'd1);
                  ptr_r      <= ptr_r + AW'(1);
                  rem_r      <= rem_r - 9'd1;
               end else begin
                  dly_cnt_r <= dly_cnt_r + CW'(1);
               end
            end
            ST_RD: begin
               // rem_r counts beats not yet presented; zero means the last one is on the bus now.
               if (rem_r == 9'd0) begin
                  state_r    <= ST_IDLE;
                  rd_valid_r <= 1'b0;
                  last_r     <= 1'b0;
                  rd_data_r  <= {DW{1'b0}};
               end else begin
                  rd_valid_r <= 1'b1;
                  rd_data_r  <= rd_word_s;
                  last_r     <= (rem_r == 9'd1);
                  ptr_r      <= ptr_r + AW'(1);
                  rem_r      <= rem_r - 9'd1;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               ack_r      <= 1'b0;
               wr_next_r  <= 1'b0;
               rd_valid_r <= 1'b0;
               last_r     <= 1'b0;
               rd_data_r  <= {DW{1'b0}};
            end
         endcase
      end
   end

   // Word RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_fire_s) begin
         for (int i = 0; i < BE; i++) begin
            if (!app_wr_en_n[i]) begin
               mem_r[ptr_r][i*8 +: 8] <= app_wr_data[i*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_sdrc_app_mem_responder.sv
// Directed and randomised bench for sdrc_app_mem_responder against a bench-side RAM model.
module tb_sdrc_app_mem_responder;

   localparam int DW      = 32;
   localparam int AW      = 10;
   localparam int ACK_DLY = 2;
   localparam int RD_LAT  = 3;
   localparam int DEPTH   = 1 << AW;

   logic        clk = 1'b0;
   logic        reset;
   logic        app_req;
   logic [29:0] app_req_addr;
   logic [8:0]  app_req_len;
   logic        app_req_wr_n;
   logic        app_req_ack;
   logic [31:0] app_wr_data;
   logic [3:0]  app_wr_en_n;
   logic        app_wr_next_req;
   logic        app_rd_valid;
   logic        app_last_rd;
   logic [31:0] app_rd_data;
   logic        busy;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] wbuf [512];
   logic [3:0]  ebuf [512];
   logic [31:0] last_word;

   sdrc_app_mem_responder #(
      .DW(DW), .AW(AW), .ACK_DLY(ACK_DLY), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .reset(reset),
      .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
      .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
      .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n), .app_wr_next_req(app_wr_next_req),
      .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd), .app_rd_data(app_rd_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic request(input logic [29:0] addr, input logic [8:0] len, input logic wr_n, input string tag);
      int lat = 0;
      @(negedge clk);
      app_req = 1'b1; app_req_addr = addr; app_req_len = len; app_req_wr_n = wr_n;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (app_req_ack === 1'b1) begin
            lat = i;
            break;
         end
      end
      app_req = 1'b0;
      n_tests++;
      if (lat != ACK_DLY + 1) begin
         n_fail++; $display("FAIL %s ack_latency: got %0d cycles, expected %0d", tag, lat, ACK_DLY + 1);
      end
   endtask

   task automatic write_burst(input logic [29:0] addr, input logic [8:0] len, input string tag);
      int beat = 0, first = 0, lastc = 0, ackbad = 0;
      request(addr, len, 1'b0, tag);
      for (int c = 1; c <= int'(len) + 4; c++) begin
         @(negedge clk);
         if (app_req_ack !== 1'b0) ackbad++;
         if (app_wr_next_req === 1'b1) begin
            if (first == 0) first = c;
            lastc = c;
            if (beat < 512) begin
               app_wr_data = wbuf[beat]; app_wr_en_n = ebuf[beat];
            end
            beat++;
         end else begin
            // Junk with all bytes enabled: must be ignored outside the data phase.
            app_wr_data = $urandom; app_wr_en_n = 4'b0000;
         end
      end
      app_wr_en_n = 4'b1111;
      for (int b = 0; b < int'(len); b++) begin
         int a = (int'(addr[AW-1:0]) + b) % DEPTH;
         for (int k = 0; k < 4; k++) if (!ebuf[b][k]) model[a][k*8 +: 8] = wbuf[b][k*8 +: 8];
      end
      n_tests++;
      if (beat != int'(len)) begin
         n_fail++; $display("FAIL %s wr_pulses: got %0d, expected %0d", tag, beat, len);
      end
      n_tests++;
      if (first != 1 || lastc != int'(len)) begin
         n_fail++; $display("FAIL %s wr_window: got first %0d last %0d, expected 1..%0d", tag, first, lastc, len);
      end
      n_tests++;
      if (ackbad != 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL %s wr_idle: got stray acks %0d busy %b, expected 0 and 0", tag, ackbad, busy);
      end
   endtask

   task automatic read_burst(input logic [29:0] addr, input logic [8:0] len, input string tag);
      int beat = 0, first = 0, lastc = 0, lastbad = 0, idlebad = 0, ackbad = 0;
      logic [31:0] exp;
      request(addr, len, 1'b1, tag);
      for (int c = 1; c <= int'(len) + RD_LAT + 4; c++) begin
         @(negedge clk);
         if (app_req_ack !== 1'b0) ackbad++;
         if (app_rd_valid === 1'b1) begin
            if (first == 0) first = c;
            lastc = c;
            exp = model[(int'(addr[AW-1:0]) + beat) % DEPTH];
            last_word = app_rd_data;
            n_tests++;
            if (app_rd_data !== exp) begin
               n_fail++; $display("FAIL %s rd_data[%0d]: got %h, expected %h", tag, beat, app_rd_data, exp);
            end
            if (app_last_rd !== (beat == int'(len) - 1)) lastbad++;
            beat++;
         end else if (app_rd_data !== 32'd0 || app_last_rd !== 1'b0) begin
            idlebad++;
         end
      end
      n_tests++;
      if (beat != int'(len) || first != RD_LAT || lastc != RD_LAT + int'(len) - 1) begin
         n_fail++; $display("FAIL %s rd_window: got %0d beats cycles %0d..%0d, expected %0d beats cycles %0d..%0d",
                            tag, beat, first, lastc, len, RD_LAT, RD_LAT + int'(len) - 1);
      end
      n_tests++;
      if (lastbad != 0 || idlebad != 0 || ackbad != 0) begin
         n_fail++; $display("FAIL %s rd_flags: got bad last %0d idle %0d ack %0d, expected all 0", tag, lastbad, idlebad, ackbad);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_tests++;
      if ({app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd, busy, app_rd_data} !== 37'd0) begin
         n_fail++; $display("FAIL reset_outputs: got ack %b wn %b v %b l %b busy %b d %h, expected all 0",
                            app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd, busy, app_rd_data);
      end
      reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || app_req_ack !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: got busy %b ack %b, expected 0 0", busy, app_req_ack);
      end
   endtask

   task automatic fill_ram();
      for (int i = 0; i < 512; i++) begin
         wbuf[i] = $urandom; ebuf[i] = 4'b0000;
      end
      write_burst(30'd0, 9'd511, "fill0");
      for (int i = 0; i < 512; i++) wbuf[i] = $urandom;
      write_burst(30'd511, 9'd511, "fill1");
      write_burst(30'd1022, 9'd2, "fill2");
   endtask

   task automatic test_write_read();
      for (int i = 0; i < 4; i++) begin
         wbuf[i] = {24'hA5A5A5, 8'hA0 + 8'(i)}; ebuf[i] = 4'b0000;
      end
      write_burst(30'h40, 9'd4, "wr40");
      read_burst(30'h40, 9'd4, "rd40");
      n_tests++;
      if (last_word !== 32'hA5A5A5A3) begin
         n_fail++; $display("FAIL rd40_last_word: got %h, expected a5a5a5a3", last_word);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) begin
         wbuf[i] = 32'h5EED0000 + 32'(i); ebuf[i] = 4'b0000;
      end
      write_burst(30'(DEPTH - 2), 9'd4, "wr_wrap");
      read_burst(30'(DEPTH - 2), 9'd4, "rd_wrap");
      read_burst(30'd0, 9'd2, "rd_wrap_low");
      n_tests++;
      if (last_word !== 32'h5EED0003) begin
         n_fail++; $display("FAIL wrap_word1: got %h, expected 5eed0003", last_word);
      end
      read_burst(30'(DEPTH - 3), 9'd1, "rd_wrap_below");
   endtask

   task automatic test_byte_mask();
      wbuf[0] = 32'hFFFFFFFF; ebuf[0] = 4'b0000;
      write_burst(30'h10, 9'd1, "wr_ff");
      wbuf[0] = 32'h12345678; ebuf[0] = 4'b1010;
      write_burst(30'h10, 9'd1, "wr_mask");
      read_burst(30'h10, 9'd1, "rd_mask");
      n_tests++;
      if (last_word !== 32'hFF34FF78) begin
         n_fail++; $display("FAIL byte_mask: got %h, expected ff34ff78", last_word);
      end
   endtask

   task automatic test_abort_zero();
      int acks = 0, pulses = 0;
      @(negedge clk);
      app_req = 1'b1; app_req_addr = 30'h80; app_req_len = 9'd4; app_req_wr_n = 1'b0;
      @(negedge clk);
      app_req = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (app_req_ack !== 1'b0) acks++;
      end
      n_tests++;
      if (acks != 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL abort: got acks %0d busy %b, expected 0 0", acks, busy);
      end
      request(30'h90, 9'd0, 1'b0, "zero_len");
      app_wr_data = 32'hDEADBEEF; app_wr_en_n = 4'b0000;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL zero_busy: got %b, expected 0", busy);
      end
      for (int c = 0; c < 4; c++) begin
         if (app_wr_next_req !== 1'b0) pulses++;
         @(negedge clk);
      end
      app_wr_en_n = 4'b1111;
      n_tests++;
      if (pulses != 0) begin
         n_fail++; $display("FAIL zero_pulses: got %0d, expected 0", pulses);
      end
      read_burst(30'h90, 9'd1, "zero_check");
   endtask

   task automatic test_reset_mid_read();
      request(30'h40, 9'd8, 1'b1, "rd_abort");
      repeat (RD_LAT + 1) @(negedge clk);
      n_tests++;
      if (app_rd_valid !== 1'b1) begin
         n_fail++; $display("FAIL mid_read_valid: got %b, expected 1", app_rd_valid);
      end
      reset = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd, busy, app_rd_data} !== 37'd0) begin
         n_fail++; $display("FAIL mid_read_reset: got v %b l %b busy %b d %h, expected all 0",
                            app_rd_valid, app_last_rd, busy, app_rd_data);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      read_burst(30'h40, 9'd4, "post_reset");
   endtask

   task automatic test_random();
      logic [29:0] addr;
      logic [8:0]  len;
      for (int n = 0; n < 20; n++) begin
         addr = {20'($urandom), 10'($urandom_range(0, DEPTH - 1))};
         len  = 9'($urandom_range(1, 64));
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < int'(len); i++) begin
               wbuf[i] = $urandom; ebuf[i] = 4'($urandom);
            end
            write_burst(addr, len, "rnd_wr");
         end
         read_burst(addr, len, "rnd_rd");
      end
   endtask

   initial begin
      reset = 1'b1; app_req = 1'b0; app_req_addr = 30'd0; app_req_len = 9'd0; app_req_wr_n = 1'b1;
      app_wr_data = 32'd0; app_wr_en_n = 4'b1111; last_word = 32'd0;
      test_reset();
      fill_ram();
      test_write_read();
      test_wrap();
      test_byte_mask();
      test_abort_zero();
      test_reset_mid_read();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
